// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line, baud tick, enable in; recovered byte and status strobes out.
interface uart_rx_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic                 rx_en;
  logic                 rx;
  logic                 s_tick;
  logic [DATAWIDTH-1:0] dout;
  logic                 rx_done;
  logic                 rx_busy;
  logic                 frame_err;

  modport master (
    output rx_en, rx, s_tick,
    input  dout, rx_done, rx_busy, frame_err
  );

  modport slave (
    input  rx_en, rx, s_tick,
    output dout, rx_done, rx_busy, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver driven by the shared s_tick baud strobe.
module uart_rx #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned SB_TICK   = 16
) (
  input logic      clk,
  input logic      rx_rst,
  uart_rx_if.slave bus
);

  localparam int unsigned SW = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int unsigned NW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;

  localparam logic [SW-1:0] SHalf = SW'(SB_TICK / 2 - 1);
  localparam logic [SW-1:0] SLast = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DATAWIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic [DATAWIDTH-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic [1:0]           sync_q;
  logic                 rx_s;

  // Two-flop synchronizer; keeps running even while rx_en is low.
  always_ff @(posedge clk) begin
    if (rx_rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.rx};
    end
  end

  assign rx_s = sync_q[1];

  // Next-state logic; every branch that leaves a state on a tick consumes that tick.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    if (bus.rx_en) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            s_d     = '0;
            state_d = StStart;
          end
        end
        StStart: begin
          if (bus.s_tick) begin
            if (s_q == SHalf) begin
              if (!rx_s) begin
                s_d     = '0;
                n_d     = '0;
                state_d = StData;
              end else begin
                // Start bit did not survive to its midpoint: treat as a glitch.
                state_d = StIdle;
              end
            end else begin
              s_d = s_q + 1'b1;
            end
          end
        end
        StData: begin
          if (bus.s_tick) begin
            if (s_q == SLast) begin
              s_d     = '0;
              shift_d = {rx_s, shift_q[DATAWIDTH-1:1]};
              if (n_q == NLast) begin
                state_d = StStop;
              end else begin
                n_d = n_q + 1'b1;
              end
            end else begin
              s_d = s_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (bus.s_tick) begin
            if (s_q == SLast) begin
              s_d = '0;
              if (rx_s) begin
                dout_d  = shift_q;
                done_d  = 1'b1;
                state_d = StIdle;
              end else begin
                ferr_d  = 1'b1;
                state_d = StBreak;
              end
            end else begin
              s_d = s_q + 1'b1;
            end
          end
        end
        StBreak: begin
          // A line held low must go high again before another start is accepted.
          if (rx_s) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  // State, counters, data and registered strobes.
  always_ff @(posedge clk) begin
    if (rx_rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.rx_done   = done_q;
  assign bus.rx_busy   = busy_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a byte-queue reference model.
module tb_uart_rx;

  localparam int unsigned BitClk = 64;

  logic clk;
  logic rx_rst;

  uart_rx_if #(.DATAWIDTH(8)) ifc ();

  uart_rx #(
    .DATAWIDTH(8),
    .SB_TICK  (16)
  ) dut (
    .clk   (clk),
    .rx_rst(rx_rst),
    .bus   (ifc.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          ferr_cnt = 0;
  int          busy_clks = 0;
  int          tick_cnt = 0;
  int          start_tick = 0;
  int          last_done_tick = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  last_good = 8'h00;
  int          exp_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one clk high every 4 clk.
  initial begin
    ifc.s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 ifc.s_tick = 1'b1;
      @(posedge clk);
      #1 ifc.s_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (ifc.s_tick && ifc.rx_en && !rx_rst) tick_cnt <= tick_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe is scored against the expected-byte queue.
  always @(negedge clk) begin
    if (!rx_rst) begin
      if (ifc.rx_busy) busy_clks++;
      if (ifc.rx_done) begin
        done_cnt++;
        last_done_tick = tick_cnt;
        check("done_ferr_excl", {31'd0, ifc.frame_err}, 0);
        check("busy_at_done", {31'd0, ifc.rx_busy}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          last_good = exp_q.pop_front();
          check("dout", {24'd0, ifc.dout}, {24'd0, last_good});
        end
      end
      if (ifc.frame_err) begin
        ferr_cnt++;
        check("dout_at_ferr", {24'd0, ifc.dout}, {24'd0, last_good});
      end
    end
  end

  task automatic drive_bit(input logic b, input int unsigned len, input bit pause);
    ifc.rx = b;
    for (int i = 0; i < int'(len); i++) begin
      @(posedge clk);
      #1;
      if (pause && i == int'(len) / 2) begin
        ifc.rx_en = 1'b0;
        repeat (100) @(posedge clk);
        #1 ifc.rx_en = 1'b1;
      end
    end
  endtask

  // pause_bit: frame bit index (0 = start) during which rx_en is dropped; -1 for none.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int pause_bit,
                            input int unsigned len);
    start_tick = tick_cnt;
    drive_bit(1'b0, len, pause_bit == 0);
    for (int i = 0; i < 8; i++) drive_bit(data[i], len, pause_bit == i + 1);
    drive_bit(stop, len, 1'b0);
  endtask

  task automatic expect_byte(input logic [7:0] data);
    exp_q.push_back(data);
    exp_done++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt < exp_done && k < budget) begin
      @(posedge clk);
      k++;
    end
    check(tag, {31'd0, done_cnt >= exp_done}, 1);
  endtask

  task automatic idle_bits(input int n);
    ifc.rx = 1'b1;
    repeat (n * BitClk) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog done=%0d exp=%0d", done_cnt, exp_done);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    int f0;
    logic [7:0] data;
    int unsigned len;

    ifc.rx    = 1'b1;
    ifc.rx_en = 1'b1;
    rx_rst    = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_rst = 1'b0;

    // Idle line after reset.
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("rst_dout", {24'd0, ifc.dout}, 0);
    check("rst_done", {31'd0, ifc.rx_done}, 0);
    check("rst_busy", {31'd0, ifc.rx_busy}, 0);
    check("rst_ferr", {31'd0, ifc.frame_err}, 0);
    check("rst_no_strobes", done_cnt + ferr_cnt, 0);
    @(posedge clk);
    #1;

    // Single byte with latency check.
    expect_byte(8'hA5);
    send_frame(8'hA5, 1'b1, -1, BitClk);
    wait_done("a5_timeout", 200);
    lat = last_done_tick - start_tick;
    check("a5_latency_ok", {31'd0, lat >= 151 && lat <= 153}, 1);
    idle_bits(2);
    check("a5_one_pulse", done_cnt, 1);

    // Back-to-back frames with no idle gap.
    expect_byte(8'h00);
    expect_byte(8'hFF);
    expect_byte(8'h3C);
    send_frame(8'h00, 1'b1, -1, BitClk);
    send_frame(8'hFF, 1'b1, -1, BitClk);
    send_frame(8'h3C, 1'b1, -1, BitClk);
    wait_done("b2b_timeout", 200);
    idle_bits(2);
    check("b2b_count", done_cnt, 4);
    check("b2b_no_ferr", ferr_cnt, 0);

    // Short glitch must not start a frame.
    d0 = done_cnt;
    busy_clks = 0;
    ifc.rx = 1'b0;
    repeat (12) @(posedge clk);
    #1 ifc.rx = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("glitch_busy_low", {31'd0, ifc.rx_busy}, 0);
    check("glitch_busy_short", {31'd0, busy_clks <= 33}, 1);
    check("glitch_no_done", done_cnt, d0);
    @(posedge clk);
    #1;

    // Bad stop bit followed by a long break.
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, -1, BitClk);
    ifc.rx = 1'b0;
    repeat (40 * BitClk) @(posedge clk);
    @(negedge clk);
    check("brk_one_ferr", ferr_cnt, f0 + 1);
    check("brk_no_done", done_cnt, d0);
    check("brk_busy", {31'd0, ifc.rx_busy}, 1);
    check("brk_dout", {24'd0, ifc.dout}, {24'd0, last_good});
    @(posedge clk);
    #1;
    idle_bits(2);
    check("brk_ferr_total", ferr_cnt, f0 + 1);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, -1, BitClk);
    wait_done("after_brk_timeout", 200);

    // Enable dropped for 100 clk during data bit 3.
    expect_byte(8'h96);
    send_frame(8'h96, 1'b1, 4, BitClk);
    wait_done("en_timeout", 200);
    @(negedge clk);
    check("en_dout", {24'd0, ifc.dout}, 32'h96);
    @(posedge clk);
    #1;
    idle_bits(1);

    // Reset during data bit 5: frame discarded, dout cleared.
    d0 = done_cnt;
    data = 8'h5A;
    drive_bit(1'b0, BitClk, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(data[i], BitClk, 1'b0);
    ifc.rx = data[5];
    repeat (BitClk / 2) @(posedge clk);
    #1 rx_rst = 1'b1;
    @(posedge clk);
    #1 rx_rst = 1'b0;
    last_good = 8'h00;
    idle_bits(12);
    @(negedge clk);
    check("rst_mid_no_done", done_cnt, d0);
    check("rst_mid_dout", {24'd0, ifc.dout}, 0);
    check("rst_mid_busy", {31'd0, ifc.rx_busy}, 0);
    @(posedge clk);
    #1;
    expect_byte(8'hC3);
    send_frame(8'hC3, 1'b1, -1, BitClk);
    wait_done("after_rst_timeout", 200);

    // Randomized bytes, bit periods within tolerance and idle gaps.
    for (int f = 0; f < 12; f++) begin
      data = 8'($urandom);
      len  = $urandom_range(66, 62);
      expect_byte(data);
      send_frame(data, 1'b1, -1, len);
      wait_done("rand_timeout", 200);
      if ($urandom_range(1, 0) == 1) idle_bits(int'($urandom_range(2, 1)));
    end
    idle_bits(2);

    check("final_done_count", done_cnt, exp_done);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_ferr_count", ferr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
